// File: rtl/decoder_scan_ctrl_if.sv
// Handshake bundle for the 2-to-4 decoder scan controller.
// master: start/stop/mode/mask/dwell out, sel/en/busy/slot_tick/done in.
interface decoder_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         sel;
  logic               en;
  logic               busy;
  logic               slot_tick;
  logic               done;

  modport master (
    output start,
    output stop,
    output mode,
    output mask,
    output dwell,
    input  sel,
    input  en,
    input  busy,
    input  slot_tick,
    input  done
  );

  modport slave (
    input  start,
    input  stop,
    input  mode,
    input  mask,
    input  dwell,
    output sel,
    output en,
    output busy,
    output slot_tick,
    output done
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scan controller stepping a 2-to-4 decoder over masked slots.
// Ports: clk, rst (async, active-high), bus (decoder_scan_ctrl_if.slave).
// Optional macro SCAN_BLANK_EN inserts one en=0 GAP cycle between slots.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  decoder_scan_ctrl_if.slave bus
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic               en_q, en_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [3:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic [3:0]         above;
  logic               last;
  logic [1:0]         nxt;
  logic               expire;
  logic               accept;

  function automatic logic [1:0] low_bit(
    input logic [3:0] m
  );
    logic [1:0] r;
    r = 2'd0;
    priority case (1'b1)
      m[0]:    r = 2'd0;
      m[1]:    r = 2'd1;
      m[2]:    r = 2'd2;
      m[3]:    r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Clear bits 0..sel; at sel=3 the shift wraps to 0 so all bits clear.
  assign above  = mask_q & ~((4'd2 << sel_q) - 4'd1);
  assign last   = (above == 4'd0);
  assign nxt    = last ? low_bit(mask_q) : low_bit(above);
  assign expire = (cnt_q == dwell_q);
  assign accept = bus.start & ~bus.stop & (|bus.mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      mask_q  <= 4'd0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        en_d  = 1'b0;
        cnt_d = '0;
        if (accept) begin
          mode_d  = bus.mode;
          mask_d  = bus.mask;
          dwell_d = bus.dwell;
          sel_d   = low_bit(bus.mask);
          en_d    = 1'b1;
          tick_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          cnt_d   = '0;
        end else if (!expire) begin
          cnt_d = cnt_q + 1'b1;
        end else if (mode_q && last) begin
          state_d = IDLE;
          en_d    = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          sel_d  = nxt;
          tick_d = 1'b1;
          cnt_d  = '0;
`ifdef SCAN_BLANK_EN
          state_d = GAP;
          en_d    = 1'b0;
`else
          en_d    = 1'b1;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      GAP: begin
        cnt_d = '0;
        if (bus.stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else begin
          state_d = SCAN;
          en_d    = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.en        = en_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.slot_tick = tick_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: queue-based sweep model plus
// directed literal checks and randomized traffic.
module tb_decoder_scan_ctrl;
  localparam int DW = 8;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  decoder_scan_ctrl_if #(.DWELL_W(DW)) bus();

  decoder_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic       tick;
  } ent_t;

  ent_t       q[$];
  logic [1:0] m_sel  = 2'd0;
  bit         m_en   = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_tick = 1'b0;
  bit         m_done = 1'b0;
  bit         m_mode = 1'b0;
  logic [3:0] m_mask = 4'd0;
  int         m_dwell = 0;

  task automatic push(input int k, input bit en, input bit tk);
    ent_t e;
    e.sel  = 2'(k);
    e.en   = en;
    e.tick = tk;
    q.push_back(e);
  endtask

  // One full pass over the latched mask, lowest slot first.
  task automatic build_sweep(input bit first);
    bit f;
    bit gap;
    f = first;
    for (int k = 0; k < 4; k++) begin
      if (m_mask[k]) begin
        gap = BLANK && !f;
        if (gap) push(k, 1'b0, 1'b1);
        push(k, 1'b1, !gap);
        for (int d = 0; d < m_dwell; d++) push(k, 1'b1, 1'b0);
        f = 1'b0;
      end
    end
  endtask

  task automatic pop_out();
    ent_t e;
    e = q.pop_front();
    m_sel  = e.sel;
    m_en   = e.en;
    m_tick = e.tick;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_sel = 2'd0; m_en = 0; m_busy = 0;
        m_tick = 0; m_done = 0;
        m_mode = 0; m_mask = 4'd0; m_dwell = 0;
      end else begin
        m_done = 1'b0;
        m_tick = 1'b0;
        if (!m_busy) begin
          m_en = 1'b0;
          if (bus.start && !bus.stop && bus.mask != 4'd0) begin
            m_mode  = bus.mode;
            m_mask  = bus.mask;
            m_dwell = int'(bus.dwell);
            q.delete();
            build_sweep(1'b1);
            pop_out();
            m_busy = 1'b1;
          end
        end else if (bus.stop) begin
          m_busy = 1'b0;
          m_en   = 1'b0;
          q.delete();
        end else if (q.size() == 0) begin
          if (m_mode) begin
            m_busy = 1'b0;
            m_en   = 1'b0;
            m_done = 1'b1;
          end else begin
            build_sweep(1'b0);
            pop_out();
          end
        end else begin
          pop_out();
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("sel", int'(bus.sel), int'(m_sel));
    chk("en", int'(bus.en), int'(m_en));
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("slot_tick", int'(bus.slot_tick), int'(m_tick));
    chk("done", int'(bus.done), int'(m_done));
  end

  task automatic go(input logic [3:0] mk, input int dw, input bit md);
    @(negedge clk);
    bus.mask  = mk;
    bus.dwell = DW'(dw);
    bus.mode  = md;
    bus.start = 1'b1;
  endtask

  int s028[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int t028[12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
  int s029[6]  = '{1, 3, 1, 3, 1, 3};
  int e030[5]  = '{1, 1, 0, 1, 1};
  int s030[5]  = '{0, 0, 1, 1, 1};

  initial begin
    int cnt;
    bit seen;
    bus.start = 0; bus.stop = 0; bus.mode = 0;
    bus.mask = 4'd0; bus.dwell = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_en", int'(bus.en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;

    // full single sweep
    go(4'hF, 2, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
`ifndef SCAN_BLANK_EN
      chk("sw_sel", int'(bus.sel), s028[i]);
      chk("sw_en", int'(bus.en), 1);
      chk("sw_tick", int'(bus.slot_tick), t028[i]);
`endif
    end
`ifndef SCAN_BLANK_EN
    @(negedge clk);
    chk("sw_done", int'(bus.done), 1);
    chk("sw_busy", int'(bus.busy), 0);
    chk("sw_en_off", int'(bus.en), 0);
    @(negedge clk);
    chk("sw_done_pulse", int'(bus.done), 0);
`endif
    repeat (6) @(negedge clk);

    // sparse continuous, then stop
    go(4'hA, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
`ifndef SCAN_BLANK_EN
      chk("sp_sel", int'(bus.sel), s029[i]);
      chk("sp_en", int'(bus.en), 1);
      chk("sp_tick", int'(bus.slot_tick), 1);
`endif
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("sp_stop_en", int'(bus.en), 0);
    chk("sp_stop_busy", int'(bus.busy), 0);
    chk("sp_stop_done", int'(bus.done), 0);

`ifdef SCAN_BLANK_EN
    go(4'h3, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("bl_en", int'(bus.en), e030[i]);
      chk("bl_sel", int'(bus.sel), s030[i]);
    end
    @(negedge clk);
    chk("bl_done", int'(bus.done), 1);
    chk("bl_busy", int'(bus.busy), 0);
`endif

    // rejected starts
    go(4'h0, 1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("rej_busy", int'(bus.busy), 0);
    chk("rej_done", int'(bus.done), 0);
    go(4'hF, 1, 1'b0);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("col_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("col_busy2", int'(bus.busy), 0);

    // reset mid-scan
    go(4'hF, 3, 1'b0);
    repeat (6) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("pre_rst_busy", int'(bus.busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_sel", int'(bus.sel), 0);
    chk("arst_en", int'(bus.en), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_tick", int'(bus.slot_tick), 0);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_busy", int'(bus.busy), 0);
      chk("post_rst_en", int'(bus.en), 0);
    end

    // max dwell
    go(4'h1, 255, 1'b1);
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.en) cnt++;
      if (bus.done) seen = 1'b1;
    end
    chk("max_en_cycles", cnt, 256);
    chk("max_done", int'(seen), 1);

    // randomized traffic
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.stop  = ($urandom_range(0, 29) == 0);
      bus.mask  = 4'($urandom);
      bus.dwell = DW'($urandom_range(0, 3));
      bus.mode  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 8: width of the dwell count.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 stop  input  1  abort the scan; sampled every cycle.
REQ-006 mode  input  1  0 = continuous, 1 = single sweep; latched on accepted start.
REQ-007 mask  input  4  slot enables, bit k = slot k; latched on accepted start.
REQ-008 dwell  input  DWELL_W  per-slot hold, in cycles minus one; latched on accepted start.
REQ-009 sel  output  2  slot select, drives the 2-to-4 decoder select input; registered.
REQ-010 en  output  1  decoder enable; registered.
REQ-011 busy  output  1  high in every state other than IDLE.
REQ-012 slot_tick  output  1  one-cycle pulse in the first cycle of each new sel value, including the first slot.
REQ-013 done  output  1  one-cycle pulse when a single sweep completes.

Function
REQ-014 States SHALL be IDLE, SCAN and GAP; GAP exists only with SCAN_BLANK_EN.
REQ-015 Start acceptance: in IDLE, start=1, stop=0 and mask!=0 SHALL latch mode, mask and dwell, then enter SCAN at the lowest set mask bit.
- en=1, busy=1 and slot_tick=1 from the next cycle.
REQ-016 Ignored starts:
- start with mask=0 SHALL be ignored; no done pulse.
- start while busy SHALL be ignored.
REQ-017 Dwell: each slot SHALL hold en=1 for exactly latched dwell+1 cycles (dwell=0 gives 1 cycle).
- Counter width DWELL_W; no overflow at dwell = all ones.
REQ-018 Slot order: next slot SHALL be the next set latched-mask bit above the current slot.
- Wraps to the lowest set bit.
- A single set bit re-selects the same slot, with slot_tick still pulsing.
REQ-019 Single sweep (mode=1): when the highest set slot's dwell expires, the next cycle SHALL have en=0, busy=0, done=1 and the block in IDLE.
REQ-020 Continuous (mode=0): the scan SHALL run until stop or rst; done never pulses.
REQ-021 Stop: stop=1 in any busy cycle SHALL give en=0, busy=0 and IDLE at the next edge.
- sel holds its last value; no done pulse.
REQ-022 Stop/start collision: stop=1 with start=1 in IDLE SHALL suppress the start.
REQ-023 Quiet outputs: in IDLE, en SHALL be 0, slot_tick 0, and sel SHALL hold its last value.
REQ-024 Input changes: mask, dwell and mode changes while busy SHALL have no effect until the next accepted start.

Reset
REQ-025 rst=1 SHALL immediately force sel=0, en=0, busy=0, slot_tick=0, done=0, dwell counter=0 and state IDLE, regardless of clk.
REQ-026 Reset mid-scan SHALL discard the latched mask, dwell and mode.
- After rst deasserts, a fresh start is required.

Configuration
REQ-027 Macro SCAN_BLANK_EN.
- Defined: between consecutive slots the block SHALL spend one GAP cycle with en=0 and sel already at the next slot; slot_tick pulses in the GAP cycle; the slot's en=1 dwell follows.
- Defined: no GAP after the final slot of a single sweep.
- Undefined: sel changes with en held at 1, no GAP state, zero blanking cycles.

Verification
REQ-028 Full single sweep, no macro: mask=4'b1111, dwell=2, mode=1, start pulse.
- -> sel 0,1,2,3, each with en=1 for 3 cycles.
- -> done one cycle after the 12th en cycle; busy low in that same cycle.
REQ-029 Sparse continuous: mask=4'b1010, dwell=0, mode=0.
- -> sel 1,3,1,3,... with en=1 every cycle and slot_tick every cycle.
- -> stop gives en=0 and busy=0 at the next edge, with no done.
REQ-030 Blanking, macro defined: mask=4'b0011, dwell=1, mode=1.
- -> en pattern 1,1,0,1,1 with sel 0,0,1,1,1, then done.
REQ-031 Rejected starts: start with mask=0 -> busy stays 0 and no done; simultaneous start and stop in IDLE -> busy stays 0.
REQ-032 Reset mid-scan: rst asserted mid-dwell during a continuous scan with mask=4'b1111.
- -> outputs 0 asynchronously, before the next clk edge.
- -> after release, block stays IDLE until a new start.
REQ-033 Max dwell: DWELL_W=8, dwell=8'hFF, mask=4'b0001, mode=1 -> en=1 for exactly 256 cycles, then done.
